note_tracker: RTL and testbench
===============================

// Module: note_tracker
// PURPOSE
//  Downstream of peak_finder: turns per-FFT-frame peak bin + magnitude into debounced MIDI
//  note-on/note-off events for the transcription back end. Maps bin->note via a boundary
//  table, requires N agreeing frames before onset, releases after M quiet frames, and
//  buffers events in a small ready/valid FIFO.
// PARAMETERS
//  BIN_W          12       width of peak bin index
//  NOTE_LO        48       MIDI number of table entry 0
//  NOTE_COUNT     37       notes covered (NOTE_LO..NOTE_LO+NOTE_COUNT-1)
//  STABLE_FRAMES  3        consecutive agreeing frames required for note-on (>=1)
//  RELEASE_FRAMES 2        consecutive quiet frames required for note-off (>=1)
//  MAG_THRESH     16'd256  peak magnitude below this = quiet frame
//  FIFO_DEPTH     8        event FIFO entries (power of 2)
// PORTS
//  clk_in            in   1      system clock (clk_m domain)
//  rst_in            in   1      asynchronous, active-low reset
//  peak_in           in   BIN_W  peak bin index of current frame
//  peak_mag_in       in   16     magnitude of that peak (unsigned)
//  peak_valid_in     in   1      single-cycle strobe, one per FFT frame
//  event_ready_in    in   1      consumer accepts event this cycle
//  event_valid_out   out  1      FIFO head valid
//  event_on_out      out  1      1 = note-on, 0 = note-off
//  event_note_out    out  7      MIDI note of event
//  note_active_out   out  1      a note is currently held
//  cur_note_out      out  7      held note (0 when none)
//  overrun_out       out  1      sticky: peak_valid_in arrived while busy
//  drop_out          out  1      sticky: event lost because FIFO full
// BEHAVIOUR
//  Reset (async assert, sync release): FSM=IDLE, counters 0, FIFO empty, all outputs 0.
//  FSM: IDLE -> SEARCH on peak_valid_in (latch bin, mag). SEARCH: one table compare/cycle,
//   idx 0..NOTE_COUNT-1; hit when BIN_EDGE[idx]<=bin<BIN_EDGE[idx+1] -> DECIDE; idx runs
//   off end -> frame "no note" -> DECIDE. DECIDE (1 cycle): update tracker, push 0-2
//   events -> IDLE. Latency strobe->event_valid_out <= NOTE_COUNT+3 cycles.
//  peak_valid_in while not IDLE: frame ignored, overrun_out<=1 (sticky until reset).
//  Frame quiet if mag<MAG_THRESH or no note. Quiet frame: cand_cnt<=0; if active,
//   rel_cnt++; rel_cnt reaching RELEASE_FRAMES -> push off(cur), active<=0, cur<=0, rel_cnt<=0.
//  Loud frame with note n: rel_cnt<=0; if n==cand then cand_cnt++ (saturate at
//   STABLE_FRAMES) else cand<=n, cand_cnt<=1. When cand_cnt reaches STABLE_FRAMES and
//   (!active or cand!=cur): if active push off(cur) then on(cand), else push on(cand);
//   cur<=cand, active<=1. Same note re-stabilising emits nothing.
//  Two-event push in DECIDE: off in first cycle, on in next (DECIDE holds 2 cycles).
//  FIFO: push when full -> event discarded, drop_out<=1; off event of a pair may be
//   dropped independently of its on. Pop on event_valid_out&&event_ready_in; same-cycle
//   push+pop when full is legal (no drop). Head outputs registered, stable while
//   valid && !ready. Empty: event_valid_out=0, event fields hold last value.
//  Widths: cand_cnt/rel_cnt saturate, never wrap; note = NOTE_LO+idx fits 7 bits.
// STRUCTURE
//  note_pkg: NOTE_LO, NOTE_COUNT, BIN_EDGE[0:NOTE_COUNT] (geometric midpoints between
//   adjacent note bins for the FFT size/rate), typedef note_event_t {logic on; logic[6:0] note;}.
//  Sub-module: note_event_fifo (sync FIFO of note_event_t, FIFO_DEPTH, full/empty).
// TESTING
//  3 frames bin=BIN_EDGE[21], mag=1000 -> one event on/69 after 3rd strobe, active=1, cur=69.
//  Then 2 frames mag=100 -> event off/69 after 2nd; 1 quiet frame alone -> no event.
//  Held 69, 3 frames at BIN_EDGE[23] -> events off/69 then on/71 in that order, cur=71.
//  Alternate bins notes 60/62 for 10 frames -> no events, cand_cnt never exceeds 1.
//  Strobe again 2 cycles after first -> overrun_out=1, 2nd frame has no effect.
//  ready=0, generate 10 events -> 8 buffered, drop_out=1; drain in order; reset mid-SEARCH
//   (rst_in=0) -> all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/note_pkg.sv
// ----------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note tracker: the MIDI range covered by the
// bin->note lookup, the bin boundary table, the tracker FSM state type and the
// note event record carried through the event FIFO.
// ----------------------------------------------------------------------------
package note_pkg;

    localparam int NOTE_LO    = 48;
    localparam int NOTE_COUNT = 37;
    localparam int EDGE_W     = 12;
    localparam int IDX_W      = 6;

    // Bin boundaries: entry i is the geometric midpoint between note NOTE_LO+i-1
    // and note NOTE_LO+i, expressed in FFT bins (8192-point FFT at 44.1 kHz,
    // ~5.383 Hz per bin). Note NOTE_LO+i owns bins BIN_EDGE[i] .. BIN_EDGE[i+1]-1.
    localparam logic [EDGE_W-1:0] BIN_EDGE [0:NOTE_COUNT] = '{
        12'd24,  12'd25,  12'd26,  12'd28,  12'd30,  12'd32,  12'd33,  12'd35,
        12'd37,  12'd40,  12'd42,  12'd45,  12'd47,  12'd50,  12'd53,  12'd56,
        12'd59,  12'd63,  12'd67,  12'd71,  12'd75,  12'd79,  12'd84,  12'd89,
        12'd94,  12'd100, 12'd106, 12'd112, 12'd119, 12'd126, 12'd134, 12'd141,
        12'd150, 12'd159, 12'd168, 12'd178, 12'd189, 12'd200
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DECIDE,
        ST_DECIDE_ON
    } tracker_state_t;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
    } note_event_t;

    function automatic logic [6:0] idx_to_note(input logic [IDX_W-1:0] idx);
        return 7'(NOTE_LO) + 7'(idx);
    endfunction

endpackage

// File: rtl/note_event_fifo.sv
// ----------------------------------------------------------------------------
// note_event_fifo
// Synchronous FIFO of note events with a registered head. The head record
// keeps its last value when the FIFO runs empty, and a push into a full FIFO
// is discarded and flagged on a sticky drop bit.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   push_i       write request
//   push_data_i  event to write
//   pop_i        consumer ready; pops when the head is valid
//   valid_o      head holds a valid event (FIFO not empty)
//   head_o       head event record
//   drop_o       sticky: a push was discarded because the FIFO was full
// ----------------------------------------------------------------------------
module note_event_fifo
    import note_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  note_event_t push_data_i,
    input  logic        pop_i,
    output logic        valid_o,
    output note_event_t head_o,
    output logic        drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    note_event_t   mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rd_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          valid_q;
    logic          drop_q;
    note_event_t   head_q;
    note_event_t   head_d;
    logic          full;
    logic          do_pop;
    logic          do_push;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a
    // push that coincides with a pop. The next head is whatever sits at the
    // new read pointer, or the incoming event when nothing else remains.
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        do_pop  = pop_i && valid_q;
        do_push = push_i && (!full || do_pop);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (count_d == '0) begin
            head_d = head_q;
        end else if (count_q == CW'(do_pop)) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            head_q  <= head_d;
            if (push_i && !do_push) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign drop_o  = drop_q;

endmodule

// File: rtl/note_tracker.sv
// ----------------------------------------------------------------------------
// note_tracker
// Turns per-frame FFT peak (bin + magnitude) into debounced MIDI note-on /
// note-off events. Each frame's bin is mapped to a note by walking the
// boundary table one entry per cycle; a note must win STABLE_FRAMES frames in
// a row before it sounds, and a held note is released after RELEASE_FRAMES
// quiet frames. Events are queued in a small ready/valid FIFO.
// Ports:
//   clk_in           clock
//   rst_in           asynchronous active-low reset
//   peak_in          peak bin index of the current frame
//   peak_mag_in      magnitude of that peak
//   peak_valid_in    one-cycle strobe per frame
//   event_ready_in   consumer accepts the head event
//   event_valid_out  head event valid
//   event_on_out     1 = note-on, 0 = note-off
//   event_note_out   MIDI note of the head event
//   note_active_out  a note is currently held
//   cur_note_out     held note, 0 when none
//   overrun_out      sticky: a frame arrived while the tracker was busy
//   drop_out         sticky: an event was lost to a full FIFO
// ----------------------------------------------------------------------------
module note_tracker
    import note_pkg::*;
#(
    parameter int          BIN_W          = 12,
    parameter int          STABLE_FRAMES  = 3,
    parameter int          RELEASE_FRAMES = 2,
    parameter logic [15:0] MAG_THRESH     = 16'd256,
    parameter int          FIFO_DEPTH     = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [BIN_W-1:0] peak_in,
    input  logic [15:0]      peak_mag_in,
    input  logic             peak_valid_in,
    input  logic             event_ready_in,
    output logic             event_valid_out,
    output logic             event_on_out,
    output logic [6:0]       event_note_out,
    output logic             note_active_out,
    output logic [6:0]       cur_note_out,
    output logic             overrun_out,
    output logic             drop_out
);

    localparam int CNT_W = $clog2(STABLE_FRAMES + 1);
    localparam int REL_W = $clog2(RELEASE_FRAMES + 1);

    tracker_state_t   state_q;
    logic [IDX_W-1:0] idx_q;
    logic [BIN_W-1:0] bin_q;
    logic [15:0]      mag_q;
    logic             hit_q;
    logic [6:0]       cand_q;
    logic [CNT_W-1:0] cand_cnt_q;
    logic [REL_W-1:0] rel_cnt_q;
    logic             active_q;
    logic [6:0]       cur_q;
    logic             overrun_q;

    logic [IDX_W-1:0] idx_next;
    logic             hit_now;
    logic             last_idx;
    logic             quiet;
    logic [6:0]       frame_note;
    logic [6:0]       cand_d;
    logic [CNT_W-1:0] cand_cnt_d;
    logic [REL_W-1:0] rel_cnt_d;
    logic             active_d;
    logic [6:0]       cur_d;
    logic             dec_off;
    logic             dec_on;
    logic             need_pair;
    logic             push;
    note_event_t      push_data;
    note_event_t      head;

    // Table walk compare for the current index, and the tracker update that
    // the DECIDE cycle commits. When a held note is replaced, the off event is
    // pushed in DECIDE and the on event for the new (already committed) held
    // note is pushed in DECIDE_ON.
    always_comb begin
        idx_next   = idx_q + IDX_W'(1);
        hit_now    = (32'(bin_q) >= 32'(BIN_EDGE[idx_q])) &&
                     (32'(bin_q) <  32'(BIN_EDGE[idx_next]));
        last_idx   = (idx_q == IDX_W'(NOTE_COUNT - 1));
        quiet      = !hit_q || (mag_q < MAG_THRESH);
        frame_note = idx_to_note(idx_q);

        cand_d     = cand_q;
        cand_cnt_d = cand_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        active_d   = active_q;
        cur_d      = cur_q;
        dec_off    = 1'b0;
        dec_on     = 1'b0;
        need_pair  = 1'b0;

        if (quiet) begin
            cand_cnt_d = '0;
            if (active_q) begin
                if (32'(rel_cnt_q) + 1 >= RELEASE_FRAMES) begin
                    dec_off   = 1'b1;
                    active_d  = 1'b0;
                    cur_d     = '0;
                    rel_cnt_d = '0;
                end else begin
                    rel_cnt_d = rel_cnt_q + REL_W'(1);
                end
            end
        end else begin
            rel_cnt_d = '0;
            if (frame_note == cand_q) begin
                if (cand_cnt_q < CNT_W'(STABLE_FRAMES)) begin
                    cand_cnt_d = cand_cnt_q + CNT_W'(1);
                end
            end else begin
                cand_d     = frame_note;
                cand_cnt_d = CNT_W'(1);
            end
            if ((cand_cnt_d == CNT_W'(STABLE_FRAMES)) && (!active_q || (cand_d != cur_q))) begin
                if (active_q) begin
                    dec_off   = 1'b1;
                    need_pair = 1'b1;
                end else begin
                    dec_on = 1'b1;
                end
                cur_d    = cand_d;
                active_d = 1'b1;
            end
        end

        push           = 1'b0;
        push_data.on   = 1'b0;
        push_data.note = cur_q;
        if (state_q == ST_DECIDE) begin
            push           = dec_off || dec_on;
            push_data.on   = !dec_off;
            push_data.note = dec_off ? cur_q : cand_d;
        end else if (state_q == ST_DECIDE_ON) begin
            push           = 1'b1;
            push_data.on   = 1'b1;
            push_data.note = cur_q;
        end
    end

    // Frame FSM with the tracker registers. A strobe outside IDLE is dropped
    // and only recorded on the sticky overrun flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            bin_q      <= '0;
            mag_q      <= '0;
            hit_q      <= 1'b0;
            cand_q     <= '0;
            cand_cnt_q <= '0;
            rel_cnt_q  <= '0;
            active_q   <= 1'b0;
            cur_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (peak_valid_in && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (peak_valid_in) begin
                        bin_q   <= peak_in;
                        mag_q   <= peak_mag_in;
                        idx_q   <= '0;
                        hit_q   <= 1'b0;
                        state_q <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (hit_now) begin
                        hit_q   <= 1'b1;
                        state_q <= ST_DECIDE;
                    end else if (last_idx) begin
                        state_q <= ST_DECIDE;
                    end else begin
                        idx_q <= idx_next;
                    end
                end
                ST_DECIDE: begin
                    cand_q     <= cand_d;
                    cand_cnt_q <= cand_cnt_d;
                    rel_cnt_q  <= rel_cnt_d;
                    active_q   <= active_d;
                    cur_q      <= cur_d;
                    state_q    <= need_pair ? ST_DECIDE_ON : ST_IDLE;
                end
                ST_DECIDE_ON: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    note_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (event_ready_in),
        .valid_o     (event_valid_out),
        .head_o      (head),
        .drop_o      (drop_out)
    );

    assign event_on_out    = head.on;
    assign event_note_out  = head.note;
    assign note_active_out = active_q;
    assign cur_note_out    = cur_q;
    assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_note_tracker.sv
// ----------------------------------------------------------------------------
// tb_note_tracker
// Directed self-checking bench for note_tracker. Frames are sent one at a
// time with enough idle cycles for the tracker to finish, and every expected
// value below is worked out by hand from the bin table and debounce rules.
// ----------------------------------------------------------------------------
module tb_note_tracker;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [11:0] peak_in = '0;
    logic [15:0] peak_mag_in = '0;
    logic        peak_valid_in = 1'b0;
    logic        event_ready_in = 1'b0;
    logic        event_valid_out;
    logic        event_on_out;
    logic [6:0]  event_note_out;
    logic        note_active_out;
    logic [6:0]  cur_note_out;
    logic        overrun_out;
    logic        drop_out;

    int errors = 0;
    int checks = 0;

    // Bin values picked from the boundary table: 79 -> note 69, 89 -> 71,
    // 47 -> 60, 53 -> 62.
    localparam logic [11:0] BIN_69 = 12'd79;
    localparam logic [11:0] BIN_71 = 12'd89;
    localparam logic [11:0] BIN_60 = 12'd47;
    localparam logic [11:0] BIN_62 = 12'd53;
    localparam logic [15:0] LOUD   = 16'd1000;
    localparam logic [15:0] SOFT   = 16'd100;

    always #5 clk_in = ~clk_in;

    note_tracker dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .peak_in         (peak_in),
        .peak_mag_in     (peak_mag_in),
        .peak_valid_in   (peak_valid_in),
        .event_ready_in  (event_ready_in),
        .event_valid_out (event_valid_out),
        .event_on_out    (event_on_out),
        .event_note_out  (event_note_out),
        .note_active_out (note_active_out),
        .cur_note_out    (cur_note_out),
        .overrun_out     (overrun_out),
        .drop_out        (drop_out)
    );

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // One frame strobe, then enough cycles for the slowest search plus a
    // two-event decision to land in the FIFO.
    task automatic applyStimulus(input logic [11:0] bin, input logic [15:0] mag);
        @(negedge clk_in);
        peak_in       = bin;
        peak_mag_in   = mag;
        peak_valid_in = 1'b1;
        @(negedge clk_in);
        peak_valid_in = 1'b0;
        waitCycles(45);
    endtask

    task automatic popEvent();
        @(negedge clk_in);
        event_ready_in = 1'b1;
        @(negedge clk_in);
        event_ready_in = 1'b0;
    endtask

    task automatic checkEvent(input string tag, input logic on, input logic [6:0] note);
        checkOutput({tag, "_valid"}, 32'(event_valid_out), 32'd1);
        checkOutput({tag, "_on"},    32'(event_on_out),    32'(on));
        checkOutput({tag, "_note"},  32'(event_note_out),  32'(note));
        popEvent();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic       exp_on   [8];
        logic [6:0] exp_note [8];
        exp_on   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_note = '{7'd69, 7'd69, 7'd71, 7'd71, 7'd69, 7'd69, 7'd71, 7'd71};

        // Reset state
        waitCycles(3);
        checkOutput("rst_valid",   32'(event_valid_out), 32'd0);
        checkOutput("rst_on",      32'(event_on_out),    32'd0);
        checkOutput("rst_note",    32'(event_note_out),  32'd0);
        checkOutput("rst_active",  32'(note_active_out), 32'd0);
        checkOutput("rst_cur",     32'(cur_note_out),    32'd0);
        checkOutput("rst_overrun", 32'(overrun_out),     32'd0);
        checkOutput("rst_drop",    32'(drop_out),        32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        waitCycles(2);

        // Onset needs three agreeing loud frames
        $display("[TB] onset of note 69");
        applyStimulus(BIN_69, LOUD);
        checkOutput("on1_valid", 32'(event_valid_out), 32'd0);
        applyStimulus(BIN_69, LOUD);
        checkOutput("on2_valid", 32'(event_valid_out), 32'd0);
        checkOutput("on2_active", 32'(note_active_out), 32'd0);
        applyStimulus(BIN_69, LOUD);
        checkOutput("on3_active", 32'(note_active_out), 32'd1);
        checkOutput("on3_cur",    32'(cur_note_out),    32'd69);
        checkEvent("on3_ev", 1'b1, 7'd69);
        checkOutput("on3_empty", 32'(event_valid_out), 32'd0);

        // Release after two quiet frames, and a lone quiet frame does nothing
        $display("[TB] release of note 69");
        applyStimulus(BIN_69, SOFT);
        checkOutput("rel1_valid",  32'(event_valid_out), 32'd0);
        checkOutput("rel1_active", 32'(note_active_out), 32'd1);
        applyStimulus(BIN_69, SOFT);
        checkOutput("rel2_active", 32'(note_active_out), 32'd0);
        checkOutput("rel2_cur",    32'(cur_note_out),    32'd0);
        checkEvent("rel2_ev", 1'b0, 7'd69);
        applyStimulus(BIN_69, SOFT);
        checkOutput("quiet_valid", 32'(event_valid_out), 32'd0);

        // Note change while held: off for the old note precedes on for the new
        $display("[TB] note change 69 -> 71");
        repeat (3) applyStimulus(BIN_69, LOUD);
        checkEvent("hold69_ev", 1'b1, 7'd69);
        applyStimulus(BIN_71, LOUD);
        applyStimulus(BIN_71, LOUD);
        checkOutput("chg2_valid", 32'(event_valid_out), 32'd0);
        checkOutput("chg2_cur",   32'(cur_note_out),    32'd69);
        applyStimulus(BIN_71, LOUD);
        checkOutput("chg3_cur", 32'(cur_note_out), 32'd71);
        checkEvent("chg_off", 1'b0, 7'd69);
        checkEvent("chg_on",  1'b1, 7'd71);
        checkOutput("chg_empty", 32'(event_valid_out), 32'd0);

        // Alternating candidates never stabilise
        $display("[TB] alternating 60/62");
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? BIN_60 : BIN_62, LOUD);
            checkOutput("alt_valid",  32'(event_valid_out), 32'd0);
            checkOutput("alt_cnt_le1", 32'(dut.cand_cnt_q <= 2'd1), 32'd1);
        end
        checkOutput("alt_cur", 32'(cur_note_out), 32'd71);

        // Overrun: a second strobe two cycles after the first is ignored.
        // Both frames are quiet; had the second counted, 71 would be released.
        $display("[TB] overrun");
        checkOutput("ovr_before", 32'(overrun_out), 32'd0);
        @(negedge clk_in);
        peak_in       = BIN_69;
        peak_mag_in   = SOFT;
        peak_valid_in = 1'b1;
        @(negedge clk_in);
        peak_valid_in = 1'b0;
        @(negedge clk_in);
        peak_valid_in = 1'b1;
        @(negedge clk_in);
        peak_valid_in = 1'b0;
        waitCycles(45);
        checkOutput("ovr_flag",   32'(overrun_out),     32'd1);
        checkOutput("ovr_active", 32'(note_active_out), 32'd1);
        checkOutput("ovr_valid",  32'(event_valid_out), 32'd0);
        applyStimulus(BIN_69, SOFT);
        checkEvent("ovr_rel", 1'b0, 7'd71);
        checkOutput("ovr_sticky", 32'(overrun_out), 32'd1);

        // FIFO overflow with the consumer stalled: ten events, eight kept
        $display("[TB] fifo overflow");
        repeat (3) applyStimulus(BIN_69, LOUD);
        repeat (3) applyStimulus(BIN_71, LOUD);
        repeat (3) applyStimulus(BIN_69, LOUD);
        repeat (3) applyStimulus(BIN_71, LOUD);
        checkOutput("ovf7_drop", 32'(drop_out), 32'd0);
        repeat (3) applyStimulus(BIN_69, LOUD);
        checkOutput("ovf9_drop", 32'(drop_out), 32'd1);
        repeat (2) applyStimulus(BIN_69, SOFT);
        checkOutput("ovf_active", 32'(note_active_out), 32'd0);
        checkOutput("ovf_cur",    32'(cur_note_out),    32'd0);
        for (int i = 0; i < 8; i++) begin
            checkEvent("drain", exp_on[i], exp_note[i]);
        end
        checkOutput("drain_empty",    32'(event_valid_out), 32'd0);
        checkOutput("drain_hold_on",  32'(event_on_out),    32'd0);
        checkOutput("drain_hold_note", 32'(event_note_out), 32'd71);

        // Reset in the middle of a search clears everything at once
        $display("[TB] reset mid-search");
        repeat (3) applyStimulus(BIN_69, LOUD);
        checkOutput("pre_rst_valid", 32'(event_valid_out), 32'd1);
        @(negedge clk_in);
        peak_in       = BIN_69;
        peak_mag_in   = LOUD;
        peak_valid_in = 1'b1;
        @(negedge clk_in);
        peak_valid_in = 1'b0;
        waitCycles(3);
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("mrst_valid",   32'(event_valid_out), 32'd0);
        checkOutput("mrst_on",      32'(event_on_out),    32'd0);
        checkOutput("mrst_note",    32'(event_note_out),  32'd0);
        checkOutput("mrst_active",  32'(note_active_out), 32'd0);
        checkOutput("mrst_cur",     32'(cur_note_out),    32'd0);
        checkOutput("mrst_overrun", 32'(overrun_out),     32'd0);
        checkOutput("mrst_drop",    32'(drop_out),        32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        waitCycles(45);
        checkOutput("post_rst_valid",  32'(event_valid_out), 32'd0);
        checkOutput("post_rst_active", 32'(note_active_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
